// File: rtl/pipeline_stage_register.sv
// Pipeline stage register with a valid/ready handshake, flush and a saturating stall counter. Latency is 1 cycle.
// Optional skid buffer (PIPELINE_STAGE_REGISTER_SKID_EN) registers in_ready; otherwise in_ready follows out_ready combinationally.
module pipeline_stage_register #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  logic                  main_valid;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign in_ready = !reset && !skid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end
    end else if (!skid_valid) begin
      if (in_fire && out_fire) begin
        main_data <= in_data;
      end else if (in_fire) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end else if (out_fire) begin
        main_valid <= 1'b0;
      end
    end else if (out_fire) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !reset && (!main_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (in_fire) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end
`endif

  // Counts stalled cycles regardless of flush; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (main_valid && !out_ready && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Randomized and directed bench for pipeline_stage_register against a queue-based occupancy model.
module tb_pipeline_stage_register;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;
`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_count;

  pipeline_stage_register #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: FIFO of held entries, stall counter, and whether out_data must still read zero after reset.
  logic [DW-1:0] q[$];
  logic [DW-1:0] seen[$];
  int  cnt = 0;
  bit  known = 0;
  bit  zero_flag = 0;
  bit  fired;
  logic          s_rdy, s_ov;
  logic [DW-1:0] s_od;
  logic [CW-1:0] s_cnt;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy,
                      input logic fl, input logic rst);
    logic exp_rdy;
    bit   ofire, ifire;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl; reset = rst;
    #1;
    s_rdy = in_ready; s_ov = out_valid; s_od = out_data; s_cnt = stall_count;
    if (CAP == 2) exp_rdy = !rst && (q.size() < 2);
    else          exp_rdy = !rst && ((q.size() == 0) || ordy);
    if (known) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      else if (zero_flag) chk("out_data_zero", out_data, '0);
      chk("stall_count", {28'b0, stall_count}, cnt);
    end else if (rst) begin
      chk("in_ready_rst", {31'b0, in_ready}, '0);
    end
    if (out_valid === 1'b1 && ordy) seen.push_back(out_data);
    fired = iv && (in_ready === 1'b1);
    if (rst) begin
      q.delete(); cnt = 0; known = 1; zero_flag = 1;
    end else begin
      if (q.size() != 0 && !ordy && cnt < CNT_MAX) cnt++;
      ofire = (q.size() != 0) && ordy;
      ifire = iv && exp_rdy;
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(id);
      if (ifire && !fl) zero_flag = 0;
      if (fl) q.delete();
    end
  endtask

  task automatic do_reset();
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
  endtask

  initial begin
    int  vcnt;
    bit  pend;

    // Reset: two cycles, then ready on the first released cycle.
    step(0, '0, 0, 0, 1);
    chk("rst_rdy0", {31'b0, s_rdy}, '0);
    step(0, '0, 0, 0, 1);
    chk("rst_rdy1", {31'b0, s_rdy}, '0);
    chk("rst_ov", {31'b0, s_ov}, '0);
    chk("rst_od", s_od, '0);
    chk("rst_cnt", {28'b0, s_cnt}, '0);
    step(0, '0, 0, 0, 0);
    chk("rst_rdy_after", {31'b0, s_rdy}, 1);

    // Streaming.
    seen.delete(); vcnt = 0;
    step(1, 32'h11, 1, 0, 0); if (s_ov) vcnt++;
    step(1, 32'h22, 1, 0, 0); if (s_ov) vcnt++;
    step(1, 32'h33, 1, 0, 0); if (s_ov) vcnt++;
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, 0, 0); if (s_ov) vcnt++;
    end
    chk("stream_vcnt", vcnt, 3);
    chk("stream_n", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("stream_0", seen[0], 32'h11);
      chk("stream_1", seen[1], 32'h22);
      chk("stream_2", seen[2], 32'h33);
    end

    // Backpressure.
    do_reset();
    seen.delete();
    step(1, 32'hA0, 1, 0, 0);
    pend = 1;
    for (int i = 0; i < 3; i++) begin
      step(pend, 32'hA1, 0, 0, 0);
      if (fired) pend = 0;
`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
      if (i == 1) chk("bp_rdy_low", {31'b0, s_rdy}, '0);
`endif
    end
    for (int i = 0; i < 4; i++) begin
      step(pend, 32'hA1, 1, 0, 0);
      if (fired) pend = 0;
    end
    chk("bp_cnt", {28'b0, s_cnt}, 3);
    chk("bp_n", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("bp_0", seen[0], 32'hA0);
      chk("bp_1", seen[1], 32'hA1);
    end

    // Flush with a same-cycle input.
    do_reset();
    step(1, 32'hC0, 1, 0, 0);
    step(1, 32'hC1, 0, 0, 0);
    step(1, 32'hC2, 0, 1, 0);
    seen.delete();
    step(0, '0, 1, 0, 0);
    chk("fl_ov", {31'b0, s_ov}, '0);
    chk("fl_cnt", {28'b0, s_cnt}, 2);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("fl_none", seen.size(), 0);
    chk("fl_cnt_hold", {28'b0, s_cnt}, 2);

    // Saturation.
    do_reset();
    step(1, 32'hD0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    chk("sat_cnt", {28'b0, s_cnt}, CNT_MAX);
    step(0, '0, 1, 0, 0);

    // Reset with entries held.
    do_reset();
    step(1, 32'hB0, 1, 0, 0);
    step(1, 32'hB1, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    seen.delete();
    step(0, '0, 1, 0, 0);
    chk("mr_ov", {31'b0, s_ov}, '0);
    chk("mr_od", s_od, '0);
    chk("mr_rdy", {31'b0, s_rdy}, 1);
    step(0, '0, 1, 0, 0);
    chk("mr_none", seen.size(), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1), $urandom, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_stage_register.md
# pipeline_stage_register

Generic, parametrised pipeline stage register with a valid/ready handshake, flush, and a saturating stall counter. It is the next generation of the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage boundary packs its fields into one `DATA_WIDTH` bus. A single `wren` enable is replaced by backpressure, so a stalled downstream stage never loses data. An optional skid buffer makes `in_ready` a registered signal for timing closure.

## Interface
- `DATA_WIDTH`, default 32: width of the packed payload bus.
- `CNT_WIDTH`, default 16: width of the stall counter.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `flush` in 1: discards all held entries. Sampled on the rising edge.
- `in_valid` in 1: upstream presents `in_data`.
- `in_ready` out 1: stage can accept. A transfer happens when `in_valid && in_ready`.
- `in_data` in `DATA_WIDTH`: upstream payload.
- `out_valid` out 1: `out_data` holds a live entry.
- `out_ready` in 1: downstream accepts. A transfer happens when `out_valid && out_ready`.
- `out_data` out `DATA_WIDTH`: payload to downstream, driven directly from the main register.
- `stall_count` out `CNT_WIDTH`: number of cycles with `out_valid && !out_ready`.

## Operation
- Storage:
  - Main register: `main_data`, `main_valid`.
  - Skid register: `skid_data`, `skid_valid`. Present only with the skid buffer compiled in.
- Occupancy states:
  - EMPTY: `!main_valid`.
  - ONE: `main_valid && !skid_valid`.
  - TWO: `main_valid && skid_valid`.
- Transitions, skid buffer compiled in. "in" = input handshake, "out" = output handshake.
  - EMPTY + in → ONE; main loads `in_data`.
  - ONE + in + out → ONE; main loads `in_data`.
  - ONE + in + !out → TWO; skid loads `in_data`.
  - ONE + !in + out → EMPTY.
  - TWO + out → ONE; main loads `skid_data`. No input is accepted in TWO, because `in_ready`=0.
  - Any other combination holds the current state.
- `in_ready` = `!reset && !skid_valid`. This depends on registers only; there is no combinational path from `out_ready`.
- `flush`:
  - Highest priority after `reset`. Next state is EMPTY.
  - Data registers keep their values.
  - A same-cycle input handshake is accepted and discarded.
  - A same-cycle output handshake completes normally.
- `reset`: clears both valids, both data registers, and `stall_count`. Overrides `flush` and all handshakes.
- `stall_count`:
  - Increments by 1 on every cycle with `out_valid && !out_ready && !reset`, including cycles where `flush` is high.
  - Saturates at 2^`CNT_WIDTH`−1; never wraps.
  - Cleared only by `reset`.
- Ordering: entries leave in acceptance order. No entry is duplicated or dropped except by `flush`.

## Timing
- Latency: 1 cycle. Data accepted at edge N appears on `out_data`, with `out_valid`=1, after edge N.
- Throughput: 1 transfer per cycle while `out_ready`=1.
- With skid: `in_ready` falls one cycle after the first `out_ready`=0 cycle that also accepts an input.
- Values during and after `reset`:
  - `out_valid`=0, `out_data`=0, `stall_count`=0.
  - `in_ready`=0 while `reset` is high; `in_ready`=1 on the first cycle after `reset` is released.
- Asserting `reset` mid-stream (state TWO) drops both entries. `out_valid`=0 after the edge.
- Both registers update on the same edge. No state is updated on any edge other than the rising edge of `clk`.

## Configuration
- Macro: `PIPELINE_STAGE_REGISTER_SKID_EN`.
- Defined: two-entry skid buffer as described above. `in_ready` is fully registered.
- Not defined:
  - No skid register; the only states are EMPTY and ONE.
  - `in_ready` = `!reset && (!main_valid || out_ready)`. This is a combinational path from `out_ready`.
  - Throughput, latency, flush, reset and counter behaviour are unchanged.

## Test plan
All scenarios use `DATA_WIDTH`=32 and `CNT_WIDTH`=4.
- Reset: hold `reset` for 2 cycles, then release.
  - Response: `out_valid`=0, `out_data`=0, `stall_count`=0, `in_ready`=0 during reset and 1 on the following cycle.
- Streaming: push 0x11, 0x22, 0x33 on consecutive cycles with `out_ready`=1.
  - Response: same values on `out_data` one cycle later, back-to-back, with `out_valid`=1 for exactly 3 cycles.
- Backpressure, skid build:
  - Stimulus: push 0xA0 then 0xA1; `out_ready`=0 starting in the cycle 0xA1 is pushed, held for 3 cycles.
  - Response: `in_ready`=0 after 0xA1 is accepted. Then 0xA0 and 0xA1 come out in order once `out_ready`=1. `stall_count`=3.
  - Non-skid build: 0xA1 is not accepted until `out_ready`=1; same output order.
- Flush in state TWO with a same-cycle `in_valid`: next cycle `out_valid`=0, no entry ever appears, and `stall_count` is unchanged by the flush.
- Counter saturation: 20 cycles of `out_valid`=1 with `out_ready`=0 → `stall_count` stops at 15.
- Reset mid-operation: assert `reset` in state TWO holding 0xB0/0xB1 → both are lost, `out_valid`=0, and `out_data`=0 after the edge.
